// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame-size limits and the
// data-bit clamp used when a frame's configuration is latched.
package uart_pkg;

    localparam int UART_MIN_BITS = 5;
    localparam int UART_MAX_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_BREAK
    } rx_state_e;

    function automatic logic [3:0] clamp_bits(input logic [3:0] req, input int max_bits);
        if (int'(req) < UART_MIN_BITS) return 4'(UART_MIN_BITS);
        if (int'(req) > max_bits)      return 4'(max_bits);
        return req;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Receive-line conditioning: 2-flop synchroniser and a 3-sample majority
// vote around the bit centre (tcnt = H-1, H, H+1; vote valid at H+1).
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter  int OVERSAMPLE = 16,
    localparam int TW         = $clog2(OVERSAMPLE)
) (
    input  logic          clk,
    input  logic          rx_rst,
    input  logic          rx,
    input  logic          s_tick,
    input  logic [TW-1:0] tcnt,
    output logic          rx_sync,
    output logic          bit_vote
);

    localparam logic [TW-1:0] T_EARLY = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_MID   = TW'(OVERSAMPLE / 2);

    logic [1:0] sync_q;
    logic       s0_q;
    logic       s1_q;

    always_ff @(posedge clk) begin
        if (rx_rst) begin
            sync_q <= 2'b11;
            s0_q   <= 1'b1;
            s1_q   <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rx};
            if (s_tick && tcnt == T_EARLY) s0_q <= sync_q[1];
            if (s_tick && tcnt == T_MID)   s1_q <= sync_q[1];
        end
    end

    assign rx_sync  = sync_q[1];
    // Third sample is the live synced line at the decision tick.
    assign bit_vote = (s0_q & s1_q) | (s0_q & rx_sync) | (s1_q & rx_sync);

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: deframes 5..9 data bits, optional parity,
// 1/2 stop bits, detects breaks and holds the frame in a valid/ready register.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | waiting for a low synced line on a tick (cfg latched here)
//   ST_START  | verifying the start bit; majority 1 is a false start
//   ST_DATA   | shifting data bits in, LSB first
//   ST_PARITY | checking the parity bit against the received data
//   ST_STOP1  | first stop bit; finishes the frame unless two stop bits
//   ST_STOP2  | second stop bit; finishes the frame
//   ST_BREAK  | all-zero frame seen; waiting for the line to return high
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS_MAX = 9,
    parameter int OVERSAMPLE    = 16
) (
    input  logic                     clk,
    input  logic                     rx_rst,
    input  logic                     s_tick,
    input  logic                     rx_en,
    input  logic                     rx,
    input  logic [3:0]               cfg_data_bits,
    input  logic                     cfg_parity_en,
    input  logic                     cfg_parity_odd,
    input  logic                     cfg_stop2,
    output logic [DATA_BITS_MAX-1:0] data_out,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     rx_done,
    output logic                     rx_busy,
    output logic                     parity_err,
    output logic                     frame_err,
    output logic                     overrun,
    output logic                     break_det
);

    localparam int            TW     = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_DEC  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

    rx_state_e                state_q, state_d;
    logic [TW-1:0]            tcnt_q, tcnt_d;
    logic [3:0]               bcnt_q, bcnt_d;
    logic [3:0]               nbits_q, nbits_d;
    logic                     par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
    logic [DATA_BITS_MAX-1:0] shreg_q, shreg_d;
    logic                     perr_q, perr_d, ferr_q, ferr_d, zero_q, zero_d;
    logic [DATA_BITS_MAX-1:0] data_out_q, data_out_d;
    logic                     valid_q, valid_d, perr_out_q, perr_out_d, ferr_out_q, ferr_out_d;
    logic                     done_q, done_d, ovr_q, ovr_d, brk_q, brk_d, busy_q, busy_d;

    logic rx_sync, bit_vote, dec, wrap, finish, brk_now;

    uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
        .clk      (clk),
        .rx_rst   (rx_rst),
        .rx       (rx),
        .s_tick   (s_tick),
        .tcnt     (tcnt_q),
        .rx_sync  (rx_sync),
        .bit_vote (bit_vote)
    );

    assign dec  = s_tick && (tcnt_q == T_DEC);
    assign wrap = s_tick && (tcnt_q == T_LAST);

    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        bcnt_d     = bcnt_q;
        nbits_d    = nbits_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        stop2_d    = stop2_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        zero_d     = zero_q;
        finish     = 1'b0;
        brk_now    = 1'b0;

        if (s_tick && state_q != ST_IDLE)
            tcnt_d = (tcnt_q == T_LAST) ? '0 : tcnt_q + TW'(1);

        case (state_q)
            ST_IDLE: begin
                if (s_tick && rx_en && !rx_sync) begin
                    state_d   = ST_START;
                    tcnt_d    = '0;
                    bcnt_d    = '0;
                    nbits_d   = clamp_bits(cfg_data_bits, DATA_BITS_MAX);
                    par_en_d  = cfg_parity_en;
                    par_odd_d = cfg_parity_odd;
                    stop2_d   = cfg_stop2;
                    shreg_d   = '0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                    zero_d    = 1'b1;
                end
            end
            ST_START: begin
                if (dec && bit_vote) state_d = ST_IDLE;
                else if (wrap)       state_d = ST_DATA;
            end
            ST_DATA: begin
                if (dec) begin
                    shreg_d[bcnt_q] = bit_vote;
                    zero_d          = zero_q & ~bit_vote;
                end
                if (wrap) begin
                    if (bcnt_q == nbits_q - 4'd1) state_d = par_en_q ? ST_PARITY : ST_STOP1;
                    else                          bcnt_d  = bcnt_q + 4'd1;
                end
            end
            ST_PARITY: begin
                if (dec) begin
                    zero_d = zero_q & ~bit_vote;
                    if (bit_vote != ((^shreg_q) ^ par_odd_q)) perr_d = 1'b1;
                end
                if (wrap) state_d = ST_STOP1;
            end
            ST_STOP1: begin
                if (dec) begin
                    zero_d = zero_q & ~bit_vote;
                    if (!bit_vote) ferr_d = 1'b1;
                    if (!stop2_q)  finish = 1'b1;
                end
                if (wrap && stop2_q) state_d = ST_STOP2;
            end
            ST_STOP2: begin
                if (dec) finish = 1'b1;
            end
            ST_BREAK: begin
                if (s_tick && rx_sync) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (finish) begin
            brk_now = zero_q & ~bit_vote;
            state_d = brk_now ? ST_BREAK : ST_IDLE;
        end

        // A capture coinciding with the handshake reloads instead of overrunning.
        done_d     = finish & ~brk_now & (~valid_q | rx_ready);
        ovr_d      = finish & ~brk_now & valid_q & ~rx_ready;
        brk_d      = finish & brk_now;
        valid_d    = valid_q & ~rx_ready;
        data_out_d = data_out_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        if (done_d) begin
            valid_d    = 1'b1;
            data_out_d = shreg_q;
            perr_out_d = perr_q;
            ferr_out_d = ferr_q | ~bit_vote;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rx_rst) begin
            state_q    <= ST_IDLE;
            tcnt_q     <= '0;
            bcnt_q     <= '0;
            nbits_q    <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            shreg_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            zero_q     <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            brk_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            bcnt_q     <= bcnt_d;
            nbits_q    <= nbits_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            stop2_q    <= stop2_d;
            shreg_q    <= shreg_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            zero_q     <= zero_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            brk_q      <= brk_d;
            busy_q     <= busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_out_q;
    assign rx_done    = done_q;
    assign overrun    = ovr_q;
    assign break_det  = brk_q;
    assign rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: frames are described at the bit level,
// the expected outcome is queued per frame and a monitor checks each event.
module tb_uart_rx_cfg;

    localparam int DBM = 9;
    localparam int OS  = 16;

    logic           clk = 1'b0;
    logic           rx_rst, s_tick, rx_en, rx, rx_ready;
    logic [3:0]     cfg_data_bits;
    logic           cfg_parity_en, cfg_parity_odd, cfg_stop2;
    logic [DBM-1:0] data_out;
    logic           rx_valid, rx_done, rx_busy, parity_err, frame_err, overrun, break_det;

    always #5 clk = ~clk;

    // Oversample tick every tick_div clocks (1 = tick held high).
    int tick_div = 4;
    int tick_cnt = 0;
    always @(posedge clk) tick_cnt <= (tick_cnt >= tick_div - 1) ? 0 : tick_cnt + 1;
    assign s_tick = (tick_cnt == tick_div - 1);

    uart_rx_cfg #(.DATA_BITS_MAX(DBM), .OVERSAMPLE(OS)) dut (
        .clk            (clk),
        .rx_rst         (rx_rst),
        .s_tick         (s_tick),
        .rx_en          (rx_en),
        .rx             (rx),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .data_out       (data_out),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .rx_done        (rx_done),
        .rx_busy        (rx_busy),
        .parity_err     (parity_err),
        .frame_err      (frame_err),
        .overrun        (overrun),
        .break_det      (break_det)
    );

    localparam int K_DONE = 0, K_OVR = 1, K_BRK = 2;
    typedef struct {
        int         kind;
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t       expq[$];
    int         checks = 0;
    int         failures = 0;
    logic       held = 1'b0;
    logic [8:0] held_data = '0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output event consumes exactly one expected entry.
    exp_t e;
    int   np, kind;
    always @(negedge clk) begin
        if (!rx_rst) begin
            np = int'(rx_done) + int'(overrun) + int'(break_det);
            if (np != 0) begin
                check("event_exclusive", np, 1);
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: done=%0b ovr=%0b brk=%0b, none expected at %0t",
                             rx_done, overrun, break_det, $time);
                end else begin
                    e    = expq.pop_front();
                    kind = rx_done ? K_DONE : (overrun ? K_OVR : K_BRK);
                    check("event_kind", kind, e.kind);
                    if (e.kind != K_BRK) begin
                        check("data_out", int'(data_out), int'(e.data));
                        check("rx_valid_held", int'(rx_valid), 1);
                    end
                    if (e.kind == K_DONE) begin
                        check("parity_err", int'(parity_err), int'(e.pe));
                        check("frame_err", int'(frame_err), int'(e.fe));
                    end
                end
            end
        end
    end

    function automatic int clamp_n(input logic [3:0] c);
        if (c < 4'd5) return 5;
        if (c > 4'd9) return 9;
        return int'(c);
    endfunction

    task automatic send_frame(input logic [8:0] word, input logic [3:0] cdb, input logic pen,
                              input logic podd, input logic s2, input logic flip,
                              input logic [1:0] stopv);
        int         nb, bt;
        logic [8:0] d;
        logic       pbit, brk, last;
        exp_t       x;
        bt   = tick_div * OS;
        nb   = clamp_n(cdb);
        d    = word & 9'((1 << nb) - 1);
        pbit = (^d) ^ podd ^ flip;
        brk  = (d == 9'd0) && (!pen || !pbit) && !stopv[0] && (!s2 || !stopv[1]);
        x.data = d;
        x.pe   = pen & flip;
        x.fe   = !stopv[0] || (s2 && !stopv[1]);
        if (brk)       x.kind = K_BRK;
        else if (held) begin x.kind = K_OVR; x.data = held_data; end
        else           x.kind = K_DONE;
        if (x.kind == K_DONE && !rx_ready) begin held = 1'b1; held_data = d; end
        expq.push_back(x);

        @(negedge clk);
        cfg_data_bits = cdb; cfg_parity_en = pen; cfg_parity_odd = podd; cfg_stop2 = s2;
        rx = 1'b0;
        repeat (bt / 2) @(negedge clk);
        // Configuration is latched at the start; later changes must be ignored.
        cfg_data_bits = 4'($urandom); cfg_parity_en = 1'($urandom);
        cfg_parity_odd = 1'($urandom); cfg_stop2 = 1'($urandom);
        repeat (bt - bt / 2) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rx = d[i];
            repeat (bt) @(negedge clk);
        end
        if (pen) begin rx = pbit; repeat (bt) @(negedge clk); end
        rx = stopv[0];
        repeat (bt) @(negedge clk);
        last = stopv[0];
        if (s2) begin rx = stopv[1]; last = stopv[1]; repeat (bt) @(negedge clk); end
        rx = 1'b1;
        if (!last) repeat (2 * bt) @(negedge clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (expq.size() != 0 && n < 20000) begin @(negedge clk); n++; end
        if (expq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d events still pending, expected 0", expq.size());
            expq.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"},   int'(data_out), 0);
        check({tag, "_rx_valid"},   int'(rx_valid), 0);
        check({tag, "_rx_busy"},    int'(rx_busy), 0);
        check({tag, "_parity_err"}, int'(parity_err), 0);
        check({tag, "_frame_err"},  int'(frame_err), 0);
    endtask

    initial begin
        int bt;
        exp_t b;
        rx = 1'b1; rx_en = 1'b1; rx_ready = 1'b1; rx_rst = 1'b1;
        cfg_data_bits = 4'd8; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
        repeat (3) @(negedge clk);
        rx_rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        bt = tick_div * OS;

        // 8N1 back-to-back
        send_frame(9'h55, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        send_frame(9'hF1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        send_frame(9'hA3, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        // 7E2 good then bad parity
        send_frame(9'h3C, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11);
        send_frame(9'h3C, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11);
        // 8N1 zero stop bit, nonzero data
        send_frame(9'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
        wait_drain();

        // Break: line low for 20 bit times, then a normal frame
        b.kind = K_BRK; b.data = '0; b.pe = 1'b0; b.fe = 1'b0;
        expq.push_back(b);
        cfg_data_bits = 4'd8; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
        rx = 1'b0;
        repeat (20 * bt) @(negedge clk);
        rx = 1'b1;
        repeat (2 * bt) @(negedge clk);
        send_frame(9'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        wait_drain();

        // Glitch of 4 ticks must be rejected
        rx = 1'b0;
        repeat (4 * tick_div) @(negedge clk);
        rx = 1'b1;
        repeat (2 * bt) @(negedge clk);
        check("glitch_busy", int'(rx_busy), 0);

        // Overrun: consumer stalled
        rx_ready = 1'b0;
        send_frame(9'h81, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        send_frame(9'h7E, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        wait_drain();
        check("ovr_hold_valid", int'(rx_valid), 1);
        check("ovr_hold_data", int'(data_out), 'h81);
        rx_ready = 1'b1;
        @(negedge clk);
        check("handshake_valid", int'(rx_valid), 0);
        check("handshake_data", int'(data_out), 'h81);
        held = 1'b0;

        // 9-bit odd parity, then a repeat aborted by reset
        send_frame(9'h1A5, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11);
        wait_drain();
        cfg_data_bits = 4'd9; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b1; cfg_stop2 = 1'b0;
        rx = 1'b0;
        repeat (bt) @(negedge clk);
        rx = 1'b1; repeat (bt) @(negedge clk);
        rx = 1'b0; repeat (bt) @(negedge clk);
        rx = 1'b1; repeat (bt / 2) @(negedge clk);
        check("midframe_busy", int'(rx_busy), 1);
        rx_rst = 1'b1;
        @(negedge clk);
        rx_rst = 1'b0;
        rx = 1'b1;
        check_reset_outputs("abort");
        repeat (3 * bt) @(negedge clk);
        check("abort_idle", int'(rx_busy), 0);

        // Randomized frames at two tick rates, including continuous ticks
        for (int k = 0; k < 24; k++) begin
            logic [1:0] sv;
            if (k == 12) begin wait_drain(); tick_div = 1; end
            sv = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            send_frame(9'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                       1'($urandom), ($urandom_range(0, 3) == 0), sv);
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
